param_main_mem: RTL
===================

PARAM_MAIN_MEM -- requirements
Module: param_main_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 256, number of words stored.
REQ-003 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-004 SHALL have parameter LATENCY, default 2, wait cycles inserted before each access (0..15).
REQ-005 SHALL have parameter ADDR_BASE, default 1, address mapping to word index 0.
REQ-006 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_i  input  1  access request.
REQ-009 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port addr_i  input  ADDR_W  word address.
REQ-011 SHALL have port be_i  input  DATA_W/8  write byte enables.
REQ-012 SHALL have port wdata_i  input  DATA_W  write data.
REQ-013 SHALL have port ready_o  output  1  block can accept a request this cycle.
REQ-014 SHALL have port rsp_valid_o  output  1  one-cycle completion pulse for reads and writes.
REQ-015 SHALL have port rdata_o  output  DATA_W  registered read data, valid with rsp_valid_o.
REQ-016 SHALL have port err_o  output  1  out-of-range flag, valid with rsp_valid_o.
REQ-017 SHALL have port async_rdata_o  output  DATA_W  combinational read of addr_i.

Function
REQ-018 SHALL use FSM states IDLE, WAIT, RESP; ready_o = 1 only in IDLE.
REQ-019 SHALL accept a request when req_i && ready_o, capturing we_i, addr_i, be_i, wdata_i.
REQ-020 SHALL transition IDLE->WAIT on accept when LATENCY>0 (counter loaded LATENCY-1), IDLE->RESP when LATENCY=0.
REQ-021 SHALL decrement counter in WAIT, going WAIT->RESP when counter is 0; RESP->IDLE unconditionally.
REQ-022 SHALL perform the array access on the edge entering RESP; rsp_valid_o = 1 for exactly the RESP cycle.
REQ-023 SHALL give response latency LATENCY+1 cycles after accept; next accept no earlier than LATENCY+2 cycles after previous.
REQ-024 SHALL compute index = addr - ADDR_BASE; out of range if addr < ADDR_BASE or index >= DEPTH.
REQ-025 SHALL on write update only bytes with be_i bit set; be_i = 0 leaves word unchanged; rdata_o holds previous value.
REQ-026 SHALL on read load rdata_o with full word; be_i ignored.
REQ-027 SHALL on out-of-range access suppress any write, load rdata_o = 0, assert err_o with rsp_valid_o.
REQ-028 SHALL hold err_o and rdata_o until the next response; err_o cleared by next in-range response.
REQ-029 SHALL ignore req_i while not IDLE (no queueing, no error).
REQ-030 SHALL drive async_rdata_o = word at index of live addr_i, 0 when out of range, reflecting writes the cycle after commit.

Reset
REQ-031 SHALL on rst_n low force IDLE, counter 0, rsp_valid_o 0, rdata_o 0, err_o 0, immediately.
REQ-032 SHALL discard an in-flight access on reset mid-operation; a write not yet committed SHALL not reach the array.
REQ-033 SHALL not reset array contents.

Structure
REQ-034 SHALL place state enum (IDLE, WAIT, RESP) and default parameter constants in package main_mem_pkg.
REQ-035 SHALL put storage in sub-module mem_array (byte-enabled write port, one sync and one async read port).
REQ-036 SHALL flag at elaboration DATA_W not multiple of 8 or LATENCY > 15.

Verification
REQ-037 SHALL test: LATENCY=2, write addr 1 data 0xDEADBEEF be 0xF, read addr 1 -> rsp_valid 3 cycles after accept, rdata 0xDEADBEEF, err 0.
REQ-038 SHALL test: word 0x11223344 at addr 5, write be 0x2 data 0xAABBCCDD -> read returns 0x1122CC44.
REQ-039 SHALL test: read addr 0 and addr 257 (DEPTH 256) -> err 1, rdata 0; write addr 0 leaves array unchanged.
REQ-040 SHALL test: req_i held high continuously, LATENCY=0 -> accept every 2 cycles, ready_o low during RESP.
REQ-041 SHALL test: rst_n low during WAIT of write to addr 3 -> outputs 0 at once, later read addr 3 returns old value.
REQ-042 SHALL test: async_rdata_o with addr_i 7 after write 0x5A5A5A5A commits -> 0x5A5A5A5A the cycle after RESP.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared constants, FSM state type and helpers for the parameterised main memory model.
package main_mem_pkg;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_DEPTH     = 256;
    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_LATENCY   = 2;
    localparam int unsigned DEF_ADDR_BASE = 1;
    localparam int unsigned MAX_LATENCY   = 15;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Index width for a given depth, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage with a byte-enabled write port, a registered read port and a combinational read port.
module mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      idx,
    input  logic                  wr_en,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    input  logic                  rd_clr,
    output logic [DATA_W-1:0]     rd_data,
    input  logic [IDX_W-1:0]      a_idx,
    input  logic                  a_ok,
    output logic [DATA_W-1:0]     a_data
);

    localparam int unsigned NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be[b]) begin
                    mem[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

    assign a_data = a_ok ? mem[a_idx] : '0;

endmodule

// File: rtl/param_main_mem.sv
// Single-port main memory model with fixed access latency, byte enables and range checking.
module param_main_mem
    import main_mem_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned LATENCY   = DEF_LATENCY,
    parameter int unsigned ADDR_BASE = DEF_ADDR_BASE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic                  ready_o,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  err_o,
    output logic [DATA_W-1:0]     async_rdata_o
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = idx_width(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(ADDR_BASE);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    if ((DATA_W % 8) != 0 || DATA_W == 0) begin : g_bad_data_w
        $error("param_main_mem: DATA_W must be a non-zero multiple of 8");
    end
    if (LATENCY > MAX_LATENCY) begin : g_bad_latency
        $error("param_main_mem: LATENCY must be in 0..15");
    end

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a >= BASE_A) && ((a - BASE_A) < DEPTH_A);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a - BASE_A);
    endfunction

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              access_c;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [NB-1:0]     be_q;
    logic [DATA_W-1:0] wdata_q;

    // With LATENCY 0 the access happens on the accept edge, so use the live request then.
    logic              cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [NB-1:0]     cur_be;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_ok;

    assign cur_we    = (state == IDLE) ? we_i    : we_q;
    assign cur_addr  = (state == IDLE) ? addr_i  : addr_q;
    assign cur_be    = (state == IDLE) ? be_i    : be_q;
    assign cur_wdata = (state == IDLE) ? wdata_i : wdata_q;
    assign cur_ok    = addr_ok(cur_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        access_c = 1'b0;
        case (state)
            IDLE: begin
                if (req_i) begin
                    if (LATENCY == 0) begin
                        state_d  = RESP;
                        access_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_d  = RESP;
                    access_c = 1'b1;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else if (req_i && state == IDLE) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            be_q    <= be_i;
            wdata_q <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_o <= 1'b0;
        end else if (access_c) begin
            err_o <= !cur_ok;
        end
    end

    assign ready_o     = (state == IDLE);
    assign rsp_valid_o = (state == RESP);

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx     (addr_idx(cur_addr)),
        .wr_en   (access_c && cur_we && cur_ok),
        .wr_be   (cur_be),
        .wr_data (cur_wdata),
        .rd_en   (access_c && !cur_we && cur_ok),
        .rd_clr  (access_c && !cur_ok),
        .rd_data (rdata_o),
        .a_idx   (addr_idx(addr_i)),
        .a_ok    (addr_ok(addr_i)),
        .a_data  (async_rdata_o)
    );

endmodule
